// File: rtl/position_tracker_pkg.sv
// Shared types and helpers for the multi-channel fringe position tracker.
package position_tracker_pkg;

    typedef struct packed {
        logic q;
        logic i;
    } quad_state_t;

    typedef enum logic [1:0] {
        DELTA_ZERO,
        DELTA_PLUS,
        DELTA_MINUS,
        DELTA_ERROR
    } delta_t;

    localparam logic MODE_QUADRATURE = 1'b0;
    localparam logic MODE_SINGLE     = 1'b1;

    // Index of a state along the forward cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] quad_phase(input quad_state_t s);
        return {s.q, s.q ^ s.i};
    endfunction

    function automatic delta_t quad_delta(input quad_state_t prev, input quad_state_t next);
        logic [1:0] step;
        step = quad_phase(next) - quad_phase(prev);
        case (step)
            2'd1:    return DELTA_PLUS;
            2'd2:    return DELTA_ERROR;
            2'd3:    return DELTA_MINUS;
            default: return DELTA_ZERO;
        endcase
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] value,
                                                   input delta_t delta,
                                                   input int unsigned width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        case (delta)
            DELTA_PLUS:  return (value >= max_v) ? max_v : value + 64'sd1;
            DELTA_MINUS: return (value <= min_v) ? min_v : value - 64'sd1;
            default:     return value;
        endcase
    endfunction

endpackage

// File: rtl/position_tracker_mc_hysteresis_comparator.sv
// Digitises one signed sample against a hysteresis window; invalid windows hold.
module hysteresis_comparator
    import position_tracker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [DATA_WIDTH-1:0] lower,
    input  logic signed [DATA_WIDTH-1:0] upper,
    input  logic                         prev_bit,
    output logic                         new_bit
);

    always_comb begin
        new_bit = prev_bit;
        if (lower <= upper) begin
            if (sample >= upper)
                new_bit = 1'b1;
            else if (sample <= lower)
                new_bit = 1'b0;
        end
    end

endmodule

// File: rtl/position_tracker_mc.sv
// Multi-channel hysteresis fringe tracker: I/Q samples in, saturating
// per-channel position words out on an AXI-stream master.
module position_tracker_mc
    import position_tracker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CHANNEL_COUNT  = 4,
    parameter int unsigned CHANNEL_WIDTH  = 2,
    parameter int unsigned POSITION_WIDTH = 32
) (
    input  logic                             SYS_aclk,
    input  logic                             SYS_areset,
    input  logic signed [DATA_WIDTH-1:0]     FC_lower_treshold,
    input  logic signed [DATA_WIDTH-1:0]     FC_upper_treshold,
    input  logic                             FC_mode,
    input  logic                             FC_clear,
    input  logic                             S_AXIS_tvalid,
    output logic                             S_AXIS_tready,
    input  logic [2*DATA_WIDTH-1:0]          S_AXIS_tdata,
    input  logic [CHANNEL_WIDTH-1:0]         S_AXIS_tuser,
    output logic                             M_AXIS_tvalid,
    input  logic                             M_AXIS_tready,
    output logic signed [POSITION_WIDTH-1:0] M_AXIS_tdata,
    output logic [CHANNEL_WIDTH-1:0]         M_AXIS_tuser,
    output logic [CHANNEL_COUNT-1:0]         ERR_flags
);

    logic [1:0] rst_sync;
    logic       rst_int;

    logic                      s1_valid;
    logic [2*DATA_WIDTH-1:0]   s1_data;
    logic [CHANNEL_WIDTH-1:0]  s1_user;

    logic                             m_valid;
    logic signed [POSITION_WIDTH-1:0] m_data;
    logic [CHANNEL_WIDTH-1:0]         m_user;

    logic signed [POSITION_WIDTH-1:0] pos_q  [CHANNEL_COUNT];
    quad_state_t                      bits_q [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0]         err_q;

    logic                             s1_adv;
    logic                             accept;
    logic                             in_range;
    logic                             update;
    logic signed [DATA_WIDTH-1:0]     sample_i;
    logic signed [DATA_WIDTH-1:0]     sample_q;
    quad_state_t                      prev_bits;
    quad_state_t                      new_bits;
    logic signed [POSITION_WIDTH-1:0] prev_pos;
    logic signed [POSITION_WIDTH-1:0] new_pos;
    logic signed [POSITION_WIDTH-1:0] out_pos;
    logic signed [63:0]               sum_wide;
    delta_t                           delta;

    // Assert asynchronously, release two clocks after SYS_areset drops.
    always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
        if (SYS_areset)
            rst_sync <= '1;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_int = rst_sync[1];

    assign s1_adv        = !m_valid || M_AXIS_tready;
    assign S_AXIS_tready = !rst_int && (!s1_valid || s1_adv);
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;
    assign in_range      = 32'(s1_user) < CHANNEL_COUNT;
    assign update        = s1_valid && s1_adv && in_range;

    assign sample_i = S1_I(s1_data);
    assign sample_q = S1_Q(s1_data);

    function automatic logic signed [DATA_WIDTH-1:0] S1_I(input logic [2*DATA_WIDTH-1:0] d);
        return d[DATA_WIDTH-1:0];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] S1_Q(input logic [2*DATA_WIDTH-1:0] d);
        return d[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    hysteresis_comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_i (
        .sample   (sample_i),
        .lower    (FC_lower_treshold),
        .upper    (FC_upper_treshold),
        .prev_bit (prev_bits.i),
        .new_bit  (new_bits.i)
    );

    hysteresis_comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_q (
        .sample   (sample_q),
        .lower    (FC_lower_treshold),
        .upper    (FC_upper_treshold),
        .prev_bit (prev_bits.q),
        .new_bit  (new_bits.q)
    );

    // Stage2 reads, computes and writes back in one cycle, so a following
    // sample of the same channel always reads the already-updated entry.
    always_comb begin
        prev_bits = '0;
        prev_pos  = '0;
        if (in_range) begin
            prev_bits = bits_q[s1_user];
            prev_pos  = pos_q[s1_user];
        end
        if (FC_mode == MODE_SINGLE)
            delta = (!prev_bits.i && new_bits.i) ? DELTA_PLUS : DELTA_ZERO;
        else
            delta = quad_delta(prev_bits, new_bits);
        sum_wide = sat_add(64'(prev_pos), delta, POSITION_WIDTH);
        new_pos  = sum_wide[POSITION_WIDTH-1:0];
        out_pos  = FC_clear ? '0 : new_pos;
    end

    always_ff @(posedge SYS_aclk or posedge rst_int) begin
        if (rst_int) begin
            for (int unsigned ch = 0; ch < CHANNEL_COUNT; ch++) begin
                pos_q[ch]  <= '0;
                bits_q[ch] <= '0;
            end
            err_q <= '0;
        end else begin
            if (update) begin
                bits_q[s1_user] <= new_bits;
                pos_q[s1_user]  <= new_pos;
                if (delta == DELTA_ERROR)
                    err_q[s1_user] <= 1'b1;
            end
            if (FC_clear) begin
                for (int unsigned ch = 0; ch < CHANNEL_COUNT; ch++)
                    pos_q[ch] <= '0;
                err_q <= '0;
            end
        end
    end

    always_ff @(posedge SYS_aclk or posedge rst_int) begin
        if (rst_int) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_user  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_user   <= '0;
        end else begin
            if (!s1_valid || s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= S_AXIS_tdata;
                    s1_user <= S_AXIS_tuser;
                end
            end
            if (s1_adv) begin
                m_valid <= s1_valid && in_range;
                if (s1_valid && in_range) begin
                    m_data <= out_pos;
                    m_user <= s1_user;
                end
            end
        end
    end

    assign M_AXIS_tvalid = m_valid;
    assign M_AXIS_tdata  = m_data;
    assign M_AXIS_tuser  = m_user;
    assign ERR_flags     = err_q;

endmodule

// File: tb/tb_position_tracker_mc.sv
// Scoreboard bench for position_tracker_mc: directed I/Q vectors, queued expectations.
module tb_position_tracker_mc;

    localparam int DW = 16;
    localparam int CC = 3;
    localparam int CW = 2;
    localparam int PW = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] lower;
    logic signed [DW-1:0] upper;
    logic                 mode;
    logic                 clear;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [2*DW-1:0]      s_tdata;
    logic [CW-1:0]        s_tuser;
    logic                 m_tvalid;
    logic                 m_tready;
    logic signed [PW-1:0] m_tdata;
    logic [CW-1:0]        m_tuser;
    logic [CC-1:0]        err_flags;

    logic rand_ready  = 1'b0;
    logic rnd_ready   = 1'b0;
    logic fixed_ready = 1'b1;
    logic mon_en      = 1'b1;

    typedef struct {
        int ch;
        int pos;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    assign m_tready = rand_ready ? rnd_ready : fixed_ready;

    position_tracker_mc #(
        .DATA_WIDTH     (DW),
        .CHANNEL_COUNT  (CC),
        .CHANNEL_WIDTH  (CW),
        .POSITION_WIDTH (PW)
    ) dut (
        .SYS_aclk          (clk),
        .SYS_areset        (rst),
        .FC_lower_treshold (lower),
        .FC_upper_treshold (upper),
        .FC_mode           (mode),
        .FC_clear          (clear),
        .S_AXIS_tvalid     (s_tvalid),
        .S_AXIS_tready     (s_tready),
        .S_AXIS_tdata      (s_tdata),
        .S_AXIS_tuser      (s_tuser),
        .M_AXIS_tvalid     (m_tvalid),
        .M_AXIS_tready     (m_tready),
        .M_AXIS_tdata      (m_tdata),
        .M_AXIS_tuser      (m_tuser),
        .ERR_flags         (err_flags)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every transfer, and checks the beat holds while stalled.
    logic                 stalled = 1'b0;
    logic signed [PW-1:0] held_d;
    logic [CW-1:0]        held_u;
    always @(negedge clk) begin
        if (!mon_en) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!m_tvalid || m_tdata !== held_d || m_tuser !== held_u) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d u=%0d, expected v=1 d=%0d u=%0d",
                             m_tvalid, m_tdata, m_tuser, held_d, held_u);
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got ch=%0d pos=%0d, expected no beat",
                             m_tuser, m_tdata);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_tuser", int'(m_tuser), b.ch);
                    check("beat_pos", int'(m_tdata), b.pos);
                end
            end
            stalled = m_tvalid && !m_tready;
            held_d  = m_tdata;
            held_u  = m_tuser;
        end
    end

    task automatic send(input int ch, input int i_s, input int q_s, input bit beat, input int exp_pos);
        beat_t b;
        bit    ok;
        s_tdata  = {DW'(q_s), DW'(i_s)};
        s_tuser  = CW'(ch);
        s_tvalid = 1'b1;
        if (beat) begin
            b.ch  = ch;
            b.pos = exp_pos;
            exp_q.push_back(b);
        end
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got tready=0 for 200 cycles, expected 1");
            s_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1 check({"drain_", tag}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fi[5] = '{-15, 15, 15, -15, -15};
        int fq[5] = '{-15, -15, 15, 15, -15};
        int ri[5] = '{-15, -15, 15, 15, -15};
        int rq[5] = '{-15, 15, 15, -15, -15};
        int sf_i[4] = '{15, 15, -15, -15};
        int sf_q[4] = '{-15, 15, 15, -15};
        int sr_i[4] = '{-15, 15, 15, -15};
        int sr_q[4] = '{15, 15, -15, -15};
        int ni[4] = '{15, 15, -15, -15};
        int nq[4] = '{15, -15, -15, 15};
        int bi[4] = '{-15, -15, 15, 15};
        int bq[4] = '{15, -15, -15, 15};
        int ci[4] = '{-15, 15, 15, -15};
        int cq[4] = '{-15, -15, 15, 15};
        int p0, p1, p2;
        beat_t b;

        lower    = -16'sd10;
        upper    = 16'sd10;
        mode     = 1'b0;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_tdata", int'(m_tdata), 0);
        check("rst_tuser", int'(m_tuser), 0);
        check("rst_err", int'(err_flags), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("rst_tready", int'(s_tready), 1);

        // Latency: presented now, visible after the second rising edge.
        s_tdata  = {DW'(-15), DW'(-15)};
        s_tuser  = '0;
        s_tvalid = 1'b1;
        b.ch  = 0;
        b.pos = 0;
        exp_q.push_back(b);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        check("lat_cycle1", int'(m_tvalid), 0);
        @(posedge clk);
        #1 check("lat_cycle2", int'(m_tvalid), 1);
        drain("latency");

        p0 = 0;
        for (int rep = 0; rep < 6; rep++)
            for (int k = 0; k < 5; k++) begin
                if (k > 0) p0++;
                send(0, fi[k], fq[k], 1'b1, p0);
            end
        drain("forward");
        check("fwd_final", p0, 24);
        check("fwd_err", int'(err_flags), 0);

        for (int rep = 0; rep < 12; rep++)
            for (int k = 0; k < 5; k++) begin
                if (k > 0) p0--;
                send(0, ri[k], rq[k], 1'b1, p0);
                send(0, (k % 2) ? 5 : -5, (k % 2) ? -5 : 5, 1'b1, p0);
            end
        drain("reverse");
        check("rev_err", int'(err_flags), 0);

        p1 = 0;
        p2 = 0;
        for (int k = 0; k < 8; k++) begin
            p0++;
            send(0, sf_i[k % 4], sf_q[k % 4], 1'b1, p0);
            p1--;
            send(1, sr_i[k % 4], sr_q[k % 4], 1'b1, p1);
            p2++;
            send(2, sf_i[k % 4], sf_q[k % 4], 1'b1, p2);
            send(3, 15, 15, 1'b0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            p2++;
            send(2, sf_i[k], sf_q[k], 1'b1, p2);
        end
        for (int k = 0; k < 4; k++) begin
            p0++;
            send(0, sf_i[k], sf_q[k], 1'b1, p0);
        end
        drain("multi");
        check("multi_err", int'(err_flags), 0);

        send(2, 15, 15, 1'b1, 12);
        drain("jump");
        check("jump_err", int'(err_flags), 4);

        // Clear lands on the same edge stage2 updates this ch1 sample.
        send(1, 15, -15, 1'b1, 0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        drain("clear");
        check("clear_err", int'(err_flags), 0);
        send(1, 15, 15, 1'b1, 1);
        send(2, -15, 15, 1'b1, 1);
        send(0, 15, -15, 1'b1, 1);
        p0 = 1;
        p1 = 1;
        p2 = 1;
        drain("post_clear");

        mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(0, -15, 0, 1'b1, p0);
            p0 = (p0 < 31) ? p0 + 1 : 31;
            send(0, 15, 0, 1'b1, p0);
        end
        drain("sat_pos");
        check("sat_final", p0, 31);

        lower = 16'sd10;
        upper = -16'sd10;
        for (int n = 0; n < 3; n++) begin
            send(1, -15, -15, 1'b1, 1);
            send(1, 15, 15, 1'b1, 1);
        end
        drain("invalid_window");
        lower = -16'sd10;
        upper = 16'sd10;
        mode  = 1'b0;
        check("single_err", int'(err_flags), 0);

        for (int n = 0; n < 40; n++) begin
            p2 = (p2 > -32) ? p2 - 1 : -32;
            send(2, ni[n % 4], nq[n % 4], 1'b1, p2);
        end
        drain("sat_neg");
        check("sat_neg_final", p2, -32);

        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            p1++;
            send(1, bi[n % 4], bq[n % 4], 1'b1, p1);
            p2++;
            send(2, ci[n % 4], cq[n % 4], 1'b1, p2);
        end
        drain("backpressure");
        rand_ready  = 1'b0;
        fixed_ready = 1'b0;
        check("bp_err", int'(err_flags), 0);

        send(0, 15, 15, 1'b1, 31);
        send(0, -15, 15, 1'b1, 31);
        mon_en = 1'b0;
        rst    = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_tvalid", int'(m_tvalid), 0);
        check("midrst_tdata", int'(m_tdata), 0);
        check("midrst_tuser", int'(m_tuser), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mon_en      = 1'b1;
        fixed_ready = 1'b1;
        check("midrst_tready", int'(s_tready), 1);
        check("midrst_tvalid_after", int'(m_tvalid), 0);
        send(0, 15, -15, 1'b1, 1);
        send(1, -15, 15, 1'b1, -1);
        drain("restart");
        check("restart_err", int'(err_flags), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
